// File: rtl/l2c_port_arbiter.sv
// l2c_port_arbiter: round-robin scheduler for the single L2 upstream port shared by IL1 reads, DL1 reads and DL1 write-backs
module l2c_port_arbiter (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        arb_hold,
    input  logic [31:0] IL1_ARADDR,
    input  logic [7:0]  IL1_ARLEN,
    input  logic [1:0]  IL1_ARBURST,
    input  logic        IL1_ARVALID,
    output logic        IL1_ARREADY,
    output logic [63:0] IL1_RDATA,
    output logic [1:0]  IL1_RRESP,
    output logic        IL1_RLAST,
    output logic        IL1_RVALID,
    input  logic        IL1_RREADY,
    input  logic [31:0] DL1_ARADDR,
    input  logic [7:0]  DL1_ARLEN,
    input  logic [1:0]  DL1_ARBURST,
    input  logic        DL1_ARVALID,
    output logic        DL1_ARREADY,
    output logic [63:0] DL1_RDATA,
    output logic [1:0]  DL1_RRESP,
    output logic        DL1_RLAST,
    output logic        DL1_RVALID,
    input  logic        DL1_RREADY,
    input  logic [31:0] DL1_AWADDR,
    input  logic [7:0]  DL1_AWLEN,
    input  logic [1:0]  DL1_AWBURST,
    input  logic        DL1_AWVALID,
    output logic        DL1_AWREADY,
    input  logic [63:0] DL1_WDATA,
    input  logic [7:0]  DL1_WSTRB,
    input  logic        DL1_WLAST,
    input  logic        DL1_WVALID,
    output logic        DL1_WREADY,
    output logic [1:0]  DL1_BRESP,
    output logic        DL1_BVALID,
    input  logic        DL1_BREADY,
    output logic [31:0] L2_ARADDR,
    output logic [7:0]  L2_ARLEN,
    output logic [1:0]  L2_ARBURST,
    output logic        L2_ARVALID,
    input  logic        L2_ARREADY,
    input  logic [63:0] L2_RDATA,
    input  logic [1:0]  L2_RRESP,
    input  logic        L2_RLAST,
    input  logic        L2_RVALID,
    output logic        L2_RREADY,
    output logic [31:0] L2_AWADDR,
    output logic [7:0]  L2_AWLEN,
    output logic [1:0]  L2_AWBURST,
    output logic        L2_AWVALID,
    input  logic        L2_AWREADY,
    output logic [63:0] L2_WDATA,
    output logic [7:0]  L2_WSTRB,
    output logic        L2_WLAST,
    output logic        L2_WVALID,
    input  logic        L2_WREADY,
    input  logic [1:0]  L2_BRESP,
    input  logic        L2_BVALID,
    output logic        L2_BREADY
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d, owner_q, owner_d, burst_q, burst_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  req, rot, gnt, sum;
    logic [1:0]  off, win;
    logic        any, idle, rd, wd, wr;

    // rotate live requests so the scan starts at ptr, then map the first hit back to a slot
    always_comb begin
        req = {DL1_AWVALID, DL1_ARVALID, IL1_ARVALID} & {3{~arb_hold & RSTn}};
        rot = 3'({req, req} >> ptr_q);
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
        sum = {1'b0, ptr_q} + {1'b0, off};
        win = sum > 3'd2 ? 2'(sum - 3'd3) : sum[1:0];
        any = |req;
        idle = state_q == IDLE;
        gnt = (idle && any) ? 3'(3'b001 << win) : 3'b000;
    end

    // next state plus capture of the winner's request on accept
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        owner_d = owner_q;
        addr_d = addr_q;
        len_d = len_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: if (any) begin
                state_d = win == 2'd2 ? WR_ADDR : RD_ADDR;
                ptr_d = win == 2'd2 ? 2'd0 : win + 2'd1;
                owner_d = win;
                addr_d = win == 2'd2 ? DL1_AWADDR : win == 2'd1 ? DL1_ARADDR : IL1_ARADDR;
                len_d = win == 2'd2 ? DL1_AWLEN : win == 2'd1 ? DL1_ARLEN : IL1_ARLEN;
                burst_d = win == 2'd2 ? DL1_AWBURST : win == 2'd1 ? DL1_ARBURST : IL1_ARBURST;
            end
            RD_ADDR: if (L2_ARREADY) state_d = RD_DATA;
            RD_DATA: if (L2_RVALID && L2_RREADY && L2_RLAST) state_d = IDLE;
            WR_ADDR: if (L2_AWREADY) state_d = WR_DATA;
            WR_DATA: if (L2_WVALID && L2_WREADY && DL1_WLAST) state_d = WR_RESP;
            WR_RESP: if (L2_BVALID && L2_BREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, pointer, owner and address registers; reset drops every handshake at once
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ptr_q <= 2'd0;
            owner_q <= 2'd0;
            addr_q <= '0;
            len_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            addr_q <= addr_d;
            len_q <= len_d;
            burst_q <= burst_d;
        end
    end

    assign rd = state_q == RD_DATA;
    assign wd = state_q == WR_DATA;
    assign wr = state_q == WR_RESP;

    assign IL1_ARREADY = gnt[0];
    assign DL1_ARREADY = gnt[1];
    assign DL1_AWREADY = gnt[2];

    assign L2_ARVALID = state_q == RD_ADDR;
    assign L2_ARADDR = addr_q;
    assign L2_ARLEN = len_q;
    assign L2_ARBURST = burst_q;
    assign L2_AWVALID = state_q == WR_ADDR;
    assign L2_AWADDR = addr_q;
    assign L2_AWLEN = len_q;
    assign L2_AWBURST = burst_q;

    assign IL1_RDATA = L2_RDATA;
    assign IL1_RRESP = L2_RRESP;
    assign IL1_RLAST = L2_RLAST;
    assign DL1_RDATA = L2_RDATA;
    assign DL1_RRESP = L2_RRESP;
    assign DL1_RLAST = L2_RLAST;
    assign IL1_RVALID = rd && owner_q == 2'd0 && L2_RVALID;
    assign DL1_RVALID = rd && owner_q == 2'd1 && L2_RVALID;
    assign L2_RREADY = rd && (owner_q == 2'd1 ? DL1_RREADY : IL1_RREADY);

    assign L2_WDATA = DL1_WDATA;
    assign L2_WSTRB = DL1_WSTRB;
    assign L2_WLAST = DL1_WLAST;
    assign L2_WVALID = wd && DL1_WVALID;
    assign DL1_WREADY = wd && L2_WREADY;

    assign DL1_BRESP = L2_BRESP;
    assign DL1_BVALID = wr && L2_BVALID;
    assign L2_BREADY = wr && DL1_BREADY;
endmodule

// File: tb/tb_l2c_port_arbiter.sv
// tb_l2c_port_arbiter: directed plus randomized bench checking l2c_port_arbiter against a transaction-level model
module tb_l2c_port_arbiter;
    logic        CLK = 1'b0, RSTn = 1'b0, arb_hold = 1'b0;
    logic [2:0]  pend = 3'b000;
    logic [31:0] raddr [3];
    logic [7:0]  rlen [3];
    logic [1:0]  rburst [3];
    logic        IL1_RREADY, DL1_RREADY, DL1_BREADY;
    logic [63:0] DL1_WDATA, L2_RDATA;
    logic [7:0]  DL1_WSTRB;
    logic        DL1_WLAST, DL1_WVALID;
    logic        L2_ARREADY, L2_AWREADY, L2_WREADY, L2_RLAST, L2_RVALID, L2_BVALID;
    logic [1:0]  L2_RRESP, L2_BRESP;
    logic        IL1_ARREADY, DL1_ARREADY, DL1_AWREADY, IL1_RLAST, IL1_RVALID, DL1_RLAST, DL1_RVALID;
    logic [63:0] IL1_RDATA, DL1_RDATA, L2_WDATA;
    logic [1:0]  IL1_RRESP, DL1_RRESP, DL1_BRESP, L2_ARBURST, L2_AWBURST;
    logic        DL1_WREADY, DL1_BVALID, L2_ARVALID, L2_RREADY, L2_AWVALID, L2_WLAST, L2_WVALID, L2_BREADY;
    logic [31:0] L2_ARADDR, L2_AWADDR;
    logic [7:0]  L2_ARLEN, L2_AWLEN, L2_WSTRB;
    int n_assert = 0, n_fail = 0, m_ptr = 0;

    l2c_port_arbiter dut (
        .CLK(CLK), .RSTn(RSTn), .arb_hold(arb_hold),
        .IL1_ARADDR(raddr[0]), .IL1_ARLEN(rlen[0]), .IL1_ARBURST(rburst[0]), .IL1_ARVALID(pend[0]),
        .IL1_ARREADY(IL1_ARREADY), .IL1_RDATA(IL1_RDATA), .IL1_RRESP(IL1_RRESP), .IL1_RLAST(IL1_RLAST),
        .IL1_RVALID(IL1_RVALID), .IL1_RREADY(IL1_RREADY),
        .DL1_ARADDR(raddr[1]), .DL1_ARLEN(rlen[1]), .DL1_ARBURST(rburst[1]), .DL1_ARVALID(pend[1]),
        .DL1_ARREADY(DL1_ARREADY), .DL1_RDATA(DL1_RDATA), .DL1_RRESP(DL1_RRESP), .DL1_RLAST(DL1_RLAST),
        .DL1_RVALID(DL1_RVALID), .DL1_RREADY(DL1_RREADY),
        .DL1_AWADDR(raddr[2]), .DL1_AWLEN(rlen[2]), .DL1_AWBURST(rburst[2]), .DL1_AWVALID(pend[2]),
        .DL1_AWREADY(DL1_AWREADY), .DL1_WDATA(DL1_WDATA), .DL1_WSTRB(DL1_WSTRB), .DL1_WLAST(DL1_WLAST),
        .DL1_WVALID(DL1_WVALID), .DL1_WREADY(DL1_WREADY), .DL1_BRESP(DL1_BRESP), .DL1_BVALID(DL1_BVALID),
        .DL1_BREADY(DL1_BREADY),
        .L2_ARADDR(L2_ARADDR), .L2_ARLEN(L2_ARLEN), .L2_ARBURST(L2_ARBURST), .L2_ARVALID(L2_ARVALID),
        .L2_ARREADY(L2_ARREADY), .L2_RDATA(L2_RDATA), .L2_RRESP(L2_RRESP), .L2_RLAST(L2_RLAST),
        .L2_RVALID(L2_RVALID), .L2_RREADY(L2_RREADY),
        .L2_AWADDR(L2_AWADDR), .L2_AWLEN(L2_AWLEN), .L2_AWBURST(L2_AWBURST), .L2_AWVALID(L2_AWVALID),
        .L2_AWREADY(L2_AWREADY), .L2_WDATA(L2_WDATA), .L2_WSTRB(L2_WSTRB), .L2_WLAST(L2_WLAST),
        .L2_WVALID(L2_WVALID), .L2_WREADY(L2_WREADY), .L2_BRESP(L2_BRESP), .L2_BVALID(L2_BVALID),
        .L2_BREADY(L2_BREADY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // model: first pending slot scanning upward from the pointer, nothing while held
    function automatic int pick();
        if (arb_hold) return -1;
        for (int k = 0; k < 3; k++)
            if (pend[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int s);
        return s < 0 ? 3'b000 : 3'(1 << s);
    endfunction

    task automatic quiet();
        L2_ARREADY = 0; L2_AWREADY = 0; L2_RVALID = 0; L2_RLAST = 0;
        L2_WREADY = 0; L2_BVALID = 0; DL1_WVALID = 0; DL1_WLAST = 0;
    endtask

    task automatic check_idle(input string tag);
        quiet();
        IL1_RREADY = 1; DL1_RREADY = 1; DL1_BREADY = 1; L2_WREADY = 1;
        L2_RVALID = 1; L2_BVALID = 1; DL1_WVALID = 1;
        #1;
        chk(tag, 64'({L2_ARVALID, L2_AWVALID, L2_RREADY, L2_BREADY, DL1_WREADY, L2_WVALID,
                      IL1_RVALID, DL1_RVALID, DL1_BVALID}), 64'(0));
        quiet();
    endtask

    // one full transaction for the model's winner, with random L2/upstream stalls
    task automatic serve(input int stall, input bit hold_mid);
        int w, n;
        bit done;
        logic [31:0] ea;
        logic [7:0] el;
        logic [1:0] eb;
        logic rv, own_rr;
        w = pick();
        quiet();
        #1;
        chk("grant", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(onehot(w)));
        if (w < 0) return;
        ea = raddr[w]; el = rlen[w]; eb = rburst[w];
        m_ptr = (w + 1) % 3;
        tick();
        pend[w] = 0;
        raddr[w] = $urandom; rlen[w] = 8'($urandom_range(0, 7)); rburst[w] = 2'($urandom);
        if (hold_mid) arb_hold = 1;
        for (int i = 0; i <= stall; i++) begin
            if (w == 2) L2_AWREADY = (i == stall); else L2_ARREADY = (i == stall);
            #1;
            chk("avalid", 64'({L2_AWVALID, L2_ARVALID}), w == 2 ? 64'(2) : 64'(1));
            chk("aaddr", 64'(w == 2 ? L2_AWADDR : L2_ARADDR), 64'(ea));
            chk("alen_burst", 64'(w == 2 ? {L2_AWLEN, L2_AWBURST} : {L2_ARLEN, L2_ARBURST}), 64'({el, eb}));
            chk("busy_ready", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(0));
            tick();
        end
        quiet();
        n = 0;
        if (w != 2) begin
            for (int c = 0; c < 200 && n <= int'(el); c++) begin
                rv = ($urandom_range(0, 3) != 0);
                IL1_RREADY = 1'($urandom); DL1_RREADY = 1'($urandom);
                own_rr = w == 0 ? IL1_RREADY : DL1_RREADY;
                L2_RVALID = rv; L2_RLAST = (n == int'(el));
                L2_RDATA = {$urandom, $urandom}; L2_RRESP = 2'($urandom);
                #1;
                chk("rvalid", 64'({DL1_RVALID, IL1_RVALID}), rv ? 64'(onehot(w)) : 64'(0));
                chk("rdata_il1", IL1_RDATA, L2_RDATA);
                chk("rdata_dl1", DL1_RDATA, L2_RDATA);
                chk("rresp_rlast", 64'({IL1_RRESP, IL1_RLAST, DL1_RRESP, DL1_RLAST}),
                    64'({L2_RRESP, L2_RLAST, L2_RRESP, L2_RLAST}));
                chk("rready", 64'(L2_RREADY), 64'(own_rr));
                if (rv && own_rr) n++;
                tick();
            end
            chk("rbeats", 64'(n), 64'(el) + 64'(1));
        end else begin
            for (int c = 0; c < 200 && n <= int'(el); c++) begin
                rv = ($urandom_range(0, 3) != 0);
                DL1_WVALID = rv; DL1_WLAST = (n == int'(el));
                DL1_WDATA = {$urandom, $urandom}; DL1_WSTRB = 8'($urandom);
                L2_WREADY = 1'($urandom);
                #1;
                chk("wvalid", 64'(L2_WVALID), 64'(rv));
                chk("wdata", L2_WDATA, DL1_WDATA);
                chk("wstrb_wlast", 64'({L2_WSTRB, L2_WLAST}), 64'({DL1_WSTRB, DL1_WLAST}));
                chk("wready", 64'(DL1_WREADY), 64'(L2_WREADY));
                if (rv && L2_WREADY) n++;
                tick();
            end
            chk("wbeats", 64'(n), 64'(el) + 64'(1));
            quiet();
            done = 0;
            for (int c = 0; c < 200 && !done; c++) begin
                rv = ($urandom_range(0, 2) != 0);
                L2_BVALID = rv; L2_BRESP = 2'($urandom); DL1_BREADY = 1'($urandom);
                L2_WREADY = 1; DL1_WVALID = 1;
                #1;
                chk("bvalid", 64'(DL1_BVALID), 64'(rv));
                chk("bresp", 64'(DL1_BRESP), 64'(L2_BRESP));
                chk("bready", 64'(L2_BREADY), 64'(DL1_BREADY));
                chk("resp_no_w", 64'({DL1_WREADY, L2_WVALID}), 64'(0));
                if (rv && DL1_BREADY) done = 1;
                tick();
            end
            chk("bdone", 64'(done), 64'(1));
        end
        quiet();
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            raddr[s] = $urandom; rlen[s] = 8'($urandom_range(0, 7)); rburst[s] = 2'($urandom);
        end
        quiet();
        IL1_RREADY = 0; DL1_RREADY = 0; DL1_BREADY = 0;
        DL1_WDATA = 0; DL1_WSTRB = 0; L2_RDATA = 0; L2_RRESP = 0; L2_BRESP = 0;
        pend = 3'b111;
        #2;
        chk("reset_ready", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(0));
        chk("reset_regs", 64'({L2_ARADDR, L2_ARLEN, L2_ARBURST}), 64'(0));
        check_idle("reset_idle");
        tick();
        RSTn = 1;
        for (int i = 0; i < 3; i++) begin
            serve(0, 0);
            check_idle("simul_idle");
        end
        raddr[0] = 32'h8000_0040; rlen[0] = 8'd3; rburst[0] = 2'd1; pend = 3'b001;
        serve(0, 0);
        check_idle("il1_idle");
        raddr[2] = 32'h8000_1000; rlen[2] = 8'd7; rburst[2] = 2'd1; pend = 3'b100;
        serve(0, 0);
        check_idle("wb_idle");
        pend = 3'b001;
        serve(5, 0);
        check_idle("bp_idle");
        arb_hold = 1;
        pend = 3'b010;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hold_grant", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(onehot(pick())));
            tick();
        end
        arb_hold = 0;
        serve(1, 1);
        arb_hold = 0;
        check_idle("hold_idle");
        pend = 3'b001;
        quiet();
        IL1_RREADY = 1;
        #1;
        chk("rst_grant", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(onehot(pick())));
        tick();
        pend = 3'b011;
        L2_ARREADY = 1;
        tick();
        L2_ARREADY = 0;
        L2_RVALID = 1;
        tick();
        #1;
        chk("mid_beat", 64'(IL1_RVALID), 64'(1));
        #2;
        RSTn = 0;
        #1;
        chk("rst_async", 64'({IL1_ARREADY, DL1_ARREADY, DL1_AWREADY, IL1_RVALID, DL1_RVALID, L2_RREADY,
                              L2_ARVALID, L2_AWVALID, L2_WVALID, DL1_WREADY, DL1_BVALID, L2_BREADY}), 64'(0));
        tick();
        RSTn = 1;
        quiet();
        m_ptr = 0;
        serve(0, 0);
        check_idle("post_rst_idle");
        serve(0, 0);
        check_idle("post_rst_idle2");
        for (int it = 0; it < 40; it++) begin
            for (int s = 0; s < 3; s++)
                if (!pend[s] && $urandom_range(0, 1) == 1) pend[s] = 1;
            if (pend == 3'b000) pend[$urandom_range(0, 2)] = 1;
            if ($urandom_range(0, 3) == 0) begin
                arb_hold = 1;
                for (int h = 0; h < 2; h++) begin
                    #1;
                    chk("rnd_hold", 64'({DL1_AWREADY, DL1_ARREADY, IL1_ARREADY}), 64'(onehot(pick())));
                    tick();
                end
                arb_hold = 0;
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3) == 0);
            arb_hold = 0;
            check_idle("rnd_idle");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
